// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: requester handshakes plus the shared external memory bus.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface mem_bus_arbiter_if;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_ACK;
  logic [31:0] IF_RDATA;

  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [31:0] DM_WDATA;
  logic        DM_ACK;
  logic [31:0] DM_RDATA;

  logic [31:0] Prog_BUS_READ;
  logic [31:0] Data_BUS_READ;
  logic [31:0] ADDR;
  logic        CS;
  logic        CS_P;
  logic        WR_RD;
  logic [31:0] Data_BUS_WRITE;

  logic        STALL;
  logic [15:0] STALL_CNT;

  modport master (
    input  IF_REQ, IF_ADDR, DM_REQ, DM_WE, DM_ADDR, DM_WDATA,
    input  Prog_BUS_READ, Data_BUS_READ,
    output IF_ACK, IF_RDATA, DM_ACK, DM_RDATA,
    output ADDR, CS, CS_P, WR_RD, Data_BUS_WRITE,
    output STALL, STALL_CNT
  );

  modport slave (
    output IF_REQ, IF_ADDR, DM_REQ, DM_WE, DM_ADDR, DM_WDATA,
    output Prog_BUS_READ, Data_BUS_READ,
    input  IF_ACK, IF_RDATA, DM_ACK, DM_RDATA,
    input  ADDR, CS, CS_P, WR_RD, Data_BUS_WRITE,
    input  STALL, STALL_CNT
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter sharing the external bus between instruction fetch and data memory.
// Define ARB_PERF_CNT_EN to build the saturating STALL_CNT performance counter.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input logic             CLK,
  input logic             RST,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    ACK
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       grant_if;
  logic       pick_if;

  // DM normally wins a tie; IF takes the bus once DM has been granted STARVE_MAX times in a row.
  always_comb begin
    pick_if = bus.IF_REQ & (~bus.DM_REQ | (starve_cnt == STARVE_LIM));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state              <= IDLE;
      wait_cnt           <= 4'd0;
      starve_cnt         <= 4'd0;
      grant_if           <= 1'b0;
      bus.IF_ACK         <= 1'b0;
      bus.DM_ACK         <= 1'b0;
      bus.IF_RDATA       <= 32'h0;
      bus.DM_RDATA       <= 32'h0;
      bus.ADDR           <= 32'h0;
      bus.CS             <= 1'b0;
      bus.CS_P           <= 1'b0;
      bus.WR_RD          <= 1'b0;
      bus.Data_BUS_WRITE <= 32'h0;
    end else begin
      bus.IF_ACK <= 1'b0;
      bus.DM_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.IF_REQ || pick_if) begin
            starve_cnt <= 4'd0;
          end else if (bus.DM_REQ && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          if (bus.IF_REQ || bus.DM_REQ) begin
            grant_if <= pick_if;
            wait_cnt <= WAIT_LOAD;
            state    <= BUS;
            if (pick_if) begin
              bus.CS_P           <= 1'b1;
              bus.CS             <= 1'b0;
              bus.WR_RD          <= 1'b0;
              bus.ADDR           <= bus.IF_ADDR;
              bus.Data_BUS_WRITE <= 32'h0;
            end else begin
              bus.CS_P           <= 1'b0;
              bus.CS             <= 1'b1;
              bus.WR_RD          <= bus.DM_WE;
              bus.ADDR           <= bus.DM_ADDR;
              bus.Data_BUS_WRITE <= bus.DM_WE ? bus.DM_WDATA : 32'h0;
            end
          end
        end
        BUS: begin
          // The bus outputs were latched at grant, so requester changes here have no effect.
          if (wait_cnt == 4'd0) begin
            if (grant_if) begin
              bus.IF_RDATA <= bus.Prog_BUS_READ;
              bus.IF_ACK   <= 1'b1;
            end else begin
              if (!bus.WR_RD) begin
                bus.DM_RDATA <= bus.Data_BUS_READ;
              end
              bus.DM_ACK <= 1'b1;
            end
            bus.ADDR           <= 32'h0;
            bus.CS             <= 1'b0;
            bus.CS_P           <= 1'b0;
            bus.WR_RD          <= 1'b0;
            bus.Data_BUS_WRITE <= 32'h0;
            state              <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.STALL = (bus.IF_REQ & ~bus.IF_ACK) | (bus.DM_REQ & ~bus.DM_ACK);

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= 16'h0;
    end else if (bus.STALL && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h1;
    end
  end

  assign bus.STALL_CNT = stall_cnt;
`else
  assign bus.STALL_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] prog_rd;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] data_rd;
    logic        cs_p;
    logic        cs;
    logic        wr_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
  } vec_t;

  localparam int NVEC = 24;
  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;
  localparam logic [31:0] IFA  = 32'h0000_1B2F;
  localparam logic [31:0] P1   = 32'h8C01_0004;
  localparam logic [31:0] DA   = 32'h0000_0350;
  localparam logic [31:0] WD   = 32'd2000;
  localparam logic [31:0] RD   = 32'd4000000;
  localparam logic [31:0] IFB  = 32'h0000_0400;
  localparam logic [31:0] P2   = 32'h2042_0001;
  localparam logic [31:0] DB   = 32'h0000_0088;
  localparam logic [31:0] RD2  = 32'hCAFE_F00D;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  int   exp_sc;
  vec_t vecs[NVEC];

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .WAIT_CYCLES(2),
    .STARVE_MAX (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic applyStimulus(input vec_t v);
    bus.IF_REQ        = v.if_req;
    bus.IF_ADDR       = v.if_addr;
    bus.Prog_BUS_READ = v.prog_rd;
    bus.DM_REQ        = v.dm_req;
    bus.DM_WE         = v.dm_we;
    bus.DM_ADDR       = v.dm_addr;
    bus.DM_WDATA      = v.dm_wdata;
    bus.Data_BUS_READ = v.data_rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expStallCnt(input int n);
`ifdef ARB_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    int   n_acks;
    int   cyc;
    int   order[6];
    int   exp_order[6];
    logic seen_ack;

    checks = 0;
    errors = 0;
    exp_sc = 0;
    exp_order = '{1, 1, 1, 1, 0, 1};
    foreach (order[i]) order[i] = -1;

    // Single fetch; Prog_BUS_READ is only valid in the capture cycle.
    vecs[0]  = '{1'b1, IFA, JUNK, 1'b0, 1'b0, Z, Z, Z,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, Z,  1'b0, Z,   1'b1};
    vecs[1]  = '{1'b1, IFA, JUNK, 1'b0, 1'b0, Z, Z, Z,    1'b1, 1'b0, 1'b0, IFA, Z,  1'b0, Z,  1'b0, Z,   1'b1};
    vecs[2]  = '{1'b1, IFA, P1,   1'b0, 1'b0, Z, Z, Z,    1'b1, 1'b0, 1'b0, IFA, Z,  1'b0, Z,  1'b0, Z,   1'b1};
    vecs[3]  = '{1'b1, IFA, JUNK, 1'b0, 1'b0, Z, Z, Z,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, P1, 1'b0, Z,   1'b0};
    vecs[4]  = '{1'b0, Z,   JUNK, 1'b0, 1'b0, Z, Z, Z,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, Z,   1'b0};
    // DM write then DM read of the same address.
    vecs[5]  = '{1'b0, Z, Z, 1'b1, 1'b1, DA, WD, JUNK,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, Z,   1'b1};
    vecs[6]  = '{1'b0, Z, Z, 1'b1, 1'b1, DA, WD, JUNK,    1'b0, 1'b1, 1'b1, DA,  WD, 1'b0, P1, 1'b0, Z,   1'b1};
    vecs[7]  = '{1'b0, Z, Z, 1'b1, 1'b1, DA, WD, JUNK,    1'b0, 1'b1, 1'b1, DA,  WD, 1'b0, P1, 1'b0, Z,   1'b1};
    vecs[8]  = '{1'b0, Z, Z, 1'b1, 1'b1, DA, WD, JUNK,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b1, Z,   1'b0};
    vecs[9]  = '{1'b0, Z, Z, 1'b0, 1'b0, Z,  Z,  Z,       1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, Z,   1'b0};
    vecs[10] = '{1'b0, Z, Z, 1'b1, 1'b0, DA, WD, JUNK,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, Z,   1'b1};
    vecs[11] = '{1'b0, Z, Z, 1'b1, 1'b0, DA, WD, JUNK,    1'b0, 1'b1, 1'b0, DA,  Z,  1'b0, P1, 1'b0, Z,   1'b1};
    vecs[12] = '{1'b0, Z, Z, 1'b1, 1'b0, DA, WD, RD,      1'b0, 1'b1, 1'b0, DA,  Z,  1'b0, P1, 1'b0, Z,   1'b1};
    vecs[13] = '{1'b0, Z, Z, 1'b1, 1'b0, DA, WD, JUNK,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b1, RD,  1'b0};
    vecs[14] = '{1'b0, Z, Z, 1'b0, 1'b0, Z,  Z,  JUNK,    1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, RD,  1'b0};
    // Simultaneous requests: DM first, then IF.
    vecs[15] = '{1'b1, IFB, JUNK, 1'b1, 1'b0, DB, Z, JUNK, 1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, RD,  1'b1};
    vecs[16] = '{1'b1, IFB, JUNK, 1'b1, 1'b0, DB, Z, JUNK, 1'b0, 1'b1, 1'b0, DB,  Z,  1'b0, P1, 1'b0, RD,  1'b1};
    vecs[17] = '{1'b1, IFB, JUNK, 1'b1, 1'b0, DB, Z, RD2,  1'b0, 1'b1, 1'b0, DB,  Z,  1'b0, P1, 1'b0, RD,  1'b1};
    vecs[18] = '{1'b1, IFB, JUNK, 1'b1, 1'b0, DB, Z, JUNK, 1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b1, RD2, 1'b1};
    vecs[19] = '{1'b1, IFB, JUNK, 1'b0, 1'b0, Z,  Z, JUNK, 1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P1, 1'b0, RD2, 1'b1};
    vecs[20] = '{1'b1, IFB, JUNK, 1'b0, 1'b0, Z,  Z, JUNK, 1'b1, 1'b0, 1'b0, IFB, Z,  1'b0, P1, 1'b0, RD2, 1'b1};
    vecs[21] = '{1'b1, IFB, P2,   1'b0, 1'b0, Z,  Z, JUNK, 1'b1, 1'b0, 1'b0, IFB, Z,  1'b0, P1, 1'b0, RD2, 1'b1};
    vecs[22] = '{1'b1, IFB, JUNK, 1'b0, 1'b0, Z,  Z, JUNK, 1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, P2, 1'b0, RD2, 1'b0};
    vecs[23] = '{1'b0, Z,   JUNK, 1'b0, 1'b0, Z,  Z, JUNK, 1'b0, 1'b0, 1'b0, Z,   Z,  1'b0, P2, 1'b0, RD2, 1'b0};

    RST = 1'b0;
    applyStimulus('0);
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rst_addr", bus.ADDR, Z);
    checkOutput("rst_cs", 32'(bus.CS), Z);
    checkOutput("rst_cs_p", 32'(bus.CS_P), Z);
    checkOutput("rst_acks", {30'h0, bus.IF_ACK, bus.DM_ACK}, Z);
    checkOutput("rst_if_rdata", bus.IF_RDATA, Z);
    checkOutput("rst_dm_rdata", bus.DM_RDATA, Z);
    checkOutput("rst_stall_cnt", 32'(bus.STALL_CNT), Z);
    checkOutput("rst_stall", 32'(bus.STALL), Z);

    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_cs_p", i), 32'(bus.CS_P), 32'(vecs[i].cs_p));
      checkOutput($sformatf("v%0d_cs", i), 32'(bus.CS), 32'(vecs[i].cs));
      checkOutput($sformatf("v%0d_wr_rd", i), 32'(bus.WR_RD), 32'(vecs[i].wr_rd));
      checkOutput($sformatf("v%0d_addr", i), bus.ADDR, vecs[i].addr);
      checkOutput($sformatf("v%0d_wdata", i), bus.Data_BUS_WRITE, vecs[i].wdata);
      checkOutput($sformatf("v%0d_if_ack", i), 32'(bus.IF_ACK), 32'(vecs[i].if_ack));
      checkOutput($sformatf("v%0d_if_rdata", i), bus.IF_RDATA, vecs[i].if_rdata);
      checkOutput($sformatf("v%0d_dm_ack", i), 32'(bus.DM_ACK), 32'(vecs[i].dm_ack));
      checkOutput($sformatf("v%0d_dm_rdata", i), bus.DM_RDATA, vecs[i].dm_rdata);
      checkOutput($sformatf("v%0d_stall", i), 32'(bus.STALL), 32'(vecs[i].stall));
      checkOutput($sformatf("v%0d_stall_cnt", i), 32'(bus.STALL_CNT), expStallCnt(exp_sc));
      exp_sc += int'(vecs[i].stall);
    end

    // Starvation: both requesters keep asking; expect D D D D I D.
    @(negedge CLK);
    bus.IF_REQ  = 1'b1;
    bus.IF_ADDR = 32'h600;
    bus.DM_REQ  = 1'b1;
    bus.DM_WE   = 1'b0;
    bus.DM_ADDR = 32'h900;
    n_acks = 0;
    cyc = 0;
    while (n_acks < 6 && cyc < 100) begin
      #1;
      if (bus.DM_ACK) begin
        order[n_acks] = 1;
        n_acks++;
      end else if (bus.IF_ACK) begin
        order[n_acks] = 0;
        n_acks++;
      end
      if (n_acks == 6) begin
        bus.IF_REQ = 1'b0;
        bus.DM_REQ = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    bus.IF_REQ = 1'b0;
    bus.DM_REQ = 1'b0;
    checkOutput("starve_ack_count", 32'(n_acks), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("starve_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end
    repeat (3) @(negedge CLK);

    // Reset asserted during the first bus cycle of a DM write.
    bus.DM_REQ   = 1'b1;
    bus.DM_WE    = 1'b1;
    bus.DM_ADDR  = DA;
    bus.DM_WDATA = WD;
    @(negedge CLK);
    #1;
    checkOutput("rst_mid_pre_cs", 32'(bus.CS), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("rst_mid_cs", 32'(bus.CS), Z);
    checkOutput("rst_mid_wr_rd", 32'(bus.WR_RD), Z);
    checkOutput("rst_mid_addr", bus.ADDR, Z);
    checkOutput("rst_mid_wdata", bus.Data_BUS_WRITE, Z);
    checkOutput("rst_mid_stall_cnt", 32'(bus.STALL_CNT), Z);
    bus.DM_REQ = 1'b0;
    seen_ack = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (bus.DM_ACK) seen_ack = 1'b1;
    end
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (bus.DM_ACK) seen_ack = 1'b1;
    end
    checkOutput("rst_mid_no_dm_ack", 32'(seen_ack), Z);

    // Fetch after reset completes with the normal latency.
    bus.IF_REQ        = 1'b1;
    bus.IF_ADDR       = 32'h44;
    bus.Prog_BUS_READ = 32'h1111_1111;
    cyc = 0;
    #1;
    while (!bus.IF_ACK && cyc < 20) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    checkOutput("post_rst_latency", 32'(cyc), 32'd3);
    checkOutput("post_rst_if_rdata", bus.IF_RDATA, 32'h1111_1111);
    checkOutput("post_rst_stall_cnt", 32'(bus.STALL_CNT), expStallCnt(3));
    bus.IF_REQ = 1'b0;
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
